uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; SHALL be an even value >= 4.
REQ-002 Parameter PARITY_EN, default 0, 1 = one parity bit follows the data bits.
REQ-003 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rx  in  1  asynchronous serial line, idle high; frame is start(0), 8 data bits LSB first, optional parity, 1 stop(1).
REQ-007 rx_data  out  8  received byte.
REQ-008 rx_valid  out  1  rx_data and status flags are valid.
REQ-009 rx_ready  in  1  consumer accepts the word.
REQ-010 parity_err  out  1  parity mismatch for the held word.
REQ-011 frame_err  out  1  stop bit sampled 0 for the held word.
REQ-012 overrun  out  1  at least one frame was dropped while the word was held.
REQ-013 busy  out  1  receiver is not in IDLE.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer, both flops reset to 1; all decisions SHALL use the synchronized value (srx).
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; busy=1 in every state except IDLE.
REQ-016 IDLE: srx=0 -> START with the bit counter cleared to 0.
REQ-017 START: sample srx at counter=CLKS_PER_BIT/2-1; sample 1 -> IDLE with no output (glitch rejection); sample 0 -> DATA with counter and bit index cleared.
REQ-018 DATA: sample srx at counter=CLKS_PER_BIT-1, shift it in LSB first, clear counter; after the 8th bit -> PARITY if PARITY_EN, else STOP.
REQ-019 PARITY: sample at counter=CLKS_PER_BIT-1; error when XOR(data bits, parity bit) != PARITY_ODD; -> STOP.
REQ-020 STOP: sample at counter=CLKS_PER_BIT-1; sample 1 -> IDLE; sample 0 -> frame_err for the frame and -> WAIT_HIGH.
REQ-021 WAIT_HIGH: remain until srx=1, then -> IDLE; a low line SHALL NOT start a new frame from this state.
REQ-022 The frame SHALL be delivered (rx_data, parity_err, frame_err loaded; rx_valid=1) on the cycle after the stop-bit sample, for both good and errored frames.
REQ-023 rx_valid SHALL stay high, and rx_data/parity_err/frame_err stable, until a cycle with rx_valid=1 and rx_ready=1; it SHALL drop on the following cycle unless a new frame is delivered in that same cycle.
REQ-024 New frame delivered while rx_valid=1 and rx_ready=0: the new frame SHALL be discarded, the held word kept, and overrun set.
REQ-025 New frame delivered in the same cycle as the handshake: the new frame SHALL load, rx_valid SHALL stay 1, and overrun SHALL be 0.
REQ-026 overrun SHALL clear on the handshake cycle that consumes the word it accompanies.
REQ-027 Counter width SHALL be $clog2(CLKS_PER_BIT); the counter SHALL never wrap outside its current state.

Reset
REQ-028 reset=1 SHALL force state IDLE, counter 0, synchronizer flops 1, rx_data=0x00, and rx_valid, parity_err, frame_err, overrun, busy all 0 on the next rising edge, including in the middle of a frame.
REQ-029 After reset is released, a partial frame still in flight SHALL be received only if srx falls from 1 to 0 again.

Verification
REQ-030 CLKS_PER_BIT=16, 8N1, send 0xA5, rx_ready=1 -> rx_data=0xA5 with rx_valid high for one cycle, 1 cycle after the stop sample; parity_err, frame_err and overrun all 0.
REQ-031 rx low for 4 clk then high -> no rx_valid; busy returns to 0 within CLKS_PER_BIT/2+3 cycles.
REQ-032 PARITY_EN=1, PARITY_ODD=0, send 0x03 with parity bit 1 -> rx_data=0x03 and parity_err=1; with parity bit 0 -> parity_err=0.
REQ-033 Send 0x5A with stop bit 0 and hold the line low for 40 bit times -> one word 0x5A with frame_err=1; busy=1 until the line returns high; no second word.
REQ-034 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11 and overrun=1; raise rx_ready -> handshake, then rx_valid=0 and overrun=0.
REQ-035 Assert reset for 1 cycle during data bit 3 of a frame -> all outputs 0 and busy=0 after the edge; a following clean 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, optional parity, and a
// one-word holding register with valid/ready handshake and overrun tracking.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CntHalf = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CntFull = CW'(CLKS_PER_BIT - 1);
    localparam logic PolOdd = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          perr;
    logic          sync1, sync2;
    logic          srx;

    assign srx  = sync2;
    assign busy = (state != StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;

            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (!srx) begin
                        state <= StStart;
                        cnt   <= '0;
                    end
                end
                StStart: begin
                    if (cnt == CntHalf) begin
                        // A start bit that is high again at mid-bit is a glitch
                        if (srx) begin
                            state <= StIdle;
                        end else begin
                            state   <= StData;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StData: begin
                    if (cnt == CntFull) begin
                        cnt     <= '0;
                        shreg   <= {srx, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= (PARITY_EN != 0) ? StParity : StStop;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StParity: begin
                    if (cnt == CntFull) begin
                        cnt   <= '0;
                        perr  <= ((^shreg) ^ srx) != PolOdd;
                        state <= StStop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt == CntFull) begin
                        cnt <= '0;
                        // Load only if the holding register is free or being consumed now
                        if (!rx_valid || rx_ready) begin
                            rx_data    <= shreg;
                            parity_err <= (PARITY_EN != 0) ? perr : 1'b0;
                            frame_err  <= !srx;
                            rx_valid   <= 1'b1;
                            overrun    <= 1'b0;
                        end else begin
                            overrun <= 1'b1;
                        end
                        state <= srx ? StIdle : StWaitHigh;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StWaitHigh: begin
                    if (srx) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8N1 instance (16 clk/bit) and an 8E1 instance
// (8 clk/bit), each with its own expectation queue and handshake monitor.
module tb_uart_rx;
    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    localparam int Cpb0 = 16;
    localparam int Cpb1 = 8;
    localparam bit Odd1 = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx0, rx1, ready0, ready1;
    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1, parity_err0, parity_err1;
    logic       frame_err0, frame_err1, overrun0, overrun1, busy0, busy1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(Cpb0), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset(reset), .rx(rx0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .rx_ready(ready0), .parity_err(parity_err0), .frame_err(frame_err0),
        .overrun(overrun0), .busy(busy0)
    );

    uart_rx #(.CLKS_PER_BIT(Cpb1), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .reset(reset), .rx(rx1), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rx_ready(ready1), .parity_err(parity_err1), .frame_err(frame_err1),
        .overrun(overrun1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference parity rule: total ones over data and parity bit must match the polarity
    function automatic logic par_err(input logic [7:0] d, input logic pb);
        return ((($countones(d) + int'(pb)) % 2) == 1) != Odd1;
    endfunction

    task automatic drive(input int id, input logic v);
        if (id == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Starts at the current negedge; with stop=0 the line is left low afterwards
    task automatic send(input int id, input logic [7:0] d, input logic has_par,
                        input logic pb, input logic stop, input int low_bits);
        int cpb;
        cpb = (id == 0) ? Cpb0 : Cpb1;
        drive(id, 1'b0);
        wait_n(cpb);
        for (int i = 0; i < 8; i++) begin
            drive(id, d[i]);
            wait_n(cpb);
        end
        if (has_par) begin
            drive(id, pb);
            wait_n(cpb);
        end
        drive(id, stop);
        wait_n(cpb);
        if (stop) drive(id, 1'b1);
        else wait_n(cpb * low_bits);
    endtask

    always @(negedge clk) begin
        #1;
        if (rx_valid0 === 1'b1 && ready0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut0_extra_word: got %0h expected no word", rx_data0);
            end else begin
                e0 = q0.pop_front();
                chk("dut0_word", 32'({rx_data0, parity_err0, frame_err0, overrun0}), 32'(e0));
            end
        end
        if (rx_valid1 === 1'b1 && ready1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut1_extra_word: got %0h expected no word", rx_data1);
            end else begin
                e1 = q1.pop_front();
                chk("dut1_word", 32'({rx_data1, parity_err1, frame_err1, overrun1}), 32'(e1));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic       pb;
        int         first;
        int         k;

        reset = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        ready0 = 1'b1;
        ready1 = 1'b1;
        wait_n(3);
        chk("reset0", 32'({rx_data0, rx_valid0, parity_err0, frame_err0, overrun0, busy0}), 0);
        chk("reset1", 32'({rx_data1, rx_valid1, parity_err1, frame_err1, overrun1, busy1}), 0);
        reset = 1'b0;
        wait_n(10);

        // 0xA5: exact delivery latency and a one-cycle valid pulse
        q0.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0, ov: 1'b0});
        first = -1;
        fork
            send(0, 8'hA5, 1'b0, 1'b0, 1'b1, 0);
            begin
                for (int i = 1; i <= 200; i++) begin
                    @(negedge clk);
                    if (rx_valid0 === 1'b1) begin
                        first = i;
                        break;
                    end
                end
                chk("a5_latency", 32'(first), 32'(9 * Cpb0 + Cpb0 / 2 + 3));
                @(negedge clk);
                chk("a5_pulse_width", 32'(rx_valid0), 0);
            end
        join
        wait_n(5);

        for (int n = 0; n < 6; n++) begin
            d = 8'($urandom);
            q0.push_back('{d: d, pe: 1'b0, fe: 1'b0, ov: 1'b0});
            send(0, d, 1'b0, 1'b0, 1'b1, 0);
            wait_n($urandom_range(0, 20));
        end

        // Short low glitch is rejected
        rx0 = 1'b0;
        wait_n(4);
        chk("glitch_busy_set", 32'(busy0), 1);
        rx0 = 1'b1;
        k = 0;
        while (busy0 && k < 7) begin
            @(negedge clk);
            k++;
        end
        chk("glitch_busy_clear", 32'(busy0), 0);
        wait_n(3 * Cpb0);

        // Bad stop bit followed by a long low line
        q0.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b1, ov: 1'b0});
        send(0, 8'h5A, 1'b0, 1'b0, 1'b0, 40);
        chk("ferr_busy_while_low", 32'(busy0), 1);
        rx0 = 1'b1;
        wait_n(5);
        chk("ferr_busy_after_high", 32'(busy0), 0);
        wait_n(2 * Cpb0);

        // Overrun: second frame dropped while first is held
        ready0 = 1'b0;
        q0.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0, ov: 1'b1});
        send(0, 8'h11, 1'b0, 1'b0, 1'b1, 0);
        send(0, 8'h22, 1'b0, 1'b0, 1'b1, 0);
        wait_n(20);
        chk("ovr_held_valid", 32'(rx_valid0), 1);
        chk("ovr_held_data", 32'(rx_data0), 32'h11);
        chk("ovr_flag", 32'(overrun0), 1);
        @(negedge clk);
        ready0 = 1'b1;
        @(negedge clk);
        chk("ovr_after_hs", 32'({rx_valid0, overrun0}), 0);
        wait_n(10);

        // Handshake in the same cycle as a new delivery
        ready0 = 1'b0;
        q0.push_back('{d: 8'h81, pe: 1'b0, fe: 1'b0, ov: 1'b0});
        send(0, 8'h81, 1'b0, 1'b0, 1'b1, 0);
        q0.push_back('{d: 8'h7E, pe: 1'b0, fe: 1'b0, ov: 1'b0});
        fork
            send(0, 8'h7E, 1'b0, 1'b0, 1'b1, 0);
            begin
                wait_n(9 * Cpb0 + Cpb0 / 2 + 2);
                ready0 = 1'b1;
                @(negedge clk);
                chk("same_cycle_load", 32'({rx_valid0, rx_data0, overrun0}), {23'd0, 1'b1, 8'h7E, 1'b0});
            end
        join
        wait_n(10);

        // Reset during data bit 3 of 0xF8; the rest of that frame is high
        fork
            send(0, 8'hF8, 1'b0, 1'b0, 1'b1, 0);
            begin
                wait_n(4 * Cpb0 + Cpb0 / 2);
                reset = 1'b1;
                @(negedge clk);
                chk("midframe_reset", 32'({rx_data0, rx_valid0, parity_err0, frame_err0, overrun0, busy0}), 0);
                reset = 1'b0;
            end
        join
        wait_n(2 * Cpb0);
        q0.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0, ov: 1'b0});
        send(0, 8'h3C, 1'b0, 1'b0, 1'b1, 0);
        wait_n(10);

        // Even-parity instance
        q1.push_back('{d: 8'h03, pe: par_err(8'h03, 1'b1), fe: 1'b0, ov: 1'b0});
        send(1, 8'h03, 1'b1, 1'b1, 1'b1, 0);
        q1.push_back('{d: 8'h03, pe: par_err(8'h03, 1'b0), fe: 1'b0, ov: 1'b0});
        send(1, 8'h03, 1'b1, 1'b0, 1'b1, 0);
        for (int n = 0; n < 8; n++) begin
            d  = 8'($urandom);
            pb = 1'($urandom);
            q1.push_back('{d: d, pe: par_err(d, pb), fe: 1'b0, ov: 1'b0});
            send(1, d, 1'b1, pb, 1'b1, 0);
            wait_n($urandom_range(0, 12));
        end

        wait_n(50);
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
